mss_capture_core: RTL and testbench

- Frame-capture sequencer for a Stonyman-style serially addressed image sensor, read through an external SPI ADC.
- Drives the sensor pointer/value pulse lines (resp, incp, resv, incv, inphi) to scan every row/column, converts each pixel over SPI, and shows status on LEDs.
- Sits between the MSS fabric clock/reset and the sensor/ADC board pins.

---
 rtl/mss_capture_pkg.sv | 37 +++
 rtl/mss_capture_core_spi_adc_rx.sv | 94 +++++++++
 rtl/mss_capture_core.sv | 196 +++++++++++++++++++
 tb/tb_mss_capture_core.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mss_capture_pkg.sv
// Shared types and constants for the Stonyman frame-capture sequencer.
// Holds the FSM encoding, sensor register indices and default parameters.
package mss_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FRAME,
    ST_SET_ROW,
    ST_SET_COL,
    ST_SETTLE,
    ST_PHI,
    ST_CONV,
    ST_NEXT
  } state_e;

  // Sensor register index equals the number of incp pulses after resp.
  localparam int COLSEL = 0;
  localparam int ROWSEL = 1;

  // Bit positions of the sensor pulse lines inside the pulse vector.
  localparam int P_RESP  = 0;
  localparam int P_INCP  = 1;
  localparam int P_RESV  = 2;
  localparam int P_INCV  = 3;
  localparam int P_INPHI = 4;

  localparam int CNT_W = 16;

  localparam int DEF_ROWS     = 112;
  localparam int DEF_COLS     = 112;
  localparam int DEF_SETTLE   = 4;
  localparam int DEF_SPI_DIV  = 2;
  localparam int DEF_SPI_BITS = 16;
  localparam int DEF_ADC_BITS = 10;
  localparam int DEF_LED_W    = 8;

endpackage

// File: rtl/mss_capture_core_spi_adc_rx.sv
// SPI receiver for the external ADC: one conversion per start pulse,
// MSB-first sample latched and done pulsed when cs returns high.
module spi_adc_rx
  import mss_capture_pkg::*;
#(
  parameter int SPI_DIV  = DEF_SPI_DIV,
  parameter int SPI_BITS = DEF_SPI_BITS,
  parameter int ADC_BITS = DEF_ADC_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                miso,
  output logic                cs,
  output logic                sclk,
  output logic                done,
  output logic [ADC_BITS-1:0] sample
);

  localparam int DIV_W = $clog2(SPI_DIV + 1);
  localparam int SEG_W = $clog2(2 * (SPI_BITS + ADC_BITS) + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SPI_DIV - 1);
  localparam logic [SEG_W-1:0] SEG_LAST = SEG_W'(2 * SPI_BITS);
  localparam logic [SEG_W-1:0] ADC_SEG  = SEG_W'(2 * ADC_BITS);

  logic                cs_q, cs_d;
  logic                sclk_q, sclk_d;
  logic                done_q, done_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [SEG_W-1:0]    seg_q, seg_d;
  logic [ADC_BITS-1:0] shift_q, shift_d;
  logic [ADC_BITS-1:0] sample_q, sample_d;

  // Segment 0 is the lead-in after cs falls; odd segments have SPI_CLK high;
  // the final even segment is the tail before cs rises.
  always_comb begin
    cs_d     = cs_q;
    div_d    = div_q;
    seg_d    = seg_q;
    shift_d  = shift_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    if (cs_q) begin
      if (start) begin
        cs_d    = 1'b0;
        div_d   = '0;
        seg_d   = '0;
        shift_d = '0;
      end
    end else if (div_q != DIV_LAST) begin
      div_d = div_q + DIV_W'(1);
    end else begin
      div_d = '0;
      if (seg_q == SEG_LAST) begin
        cs_d     = 1'b1;
        sample_d = shift_q;
        done_d   = 1'b1;
      end else begin
        seg_d = seg_q + SEG_W'(1);
        // Entering an odd segment is the SPI_CLK rising edge.
        if (!seg_q[0] && (seg_q < ADC_SEG)) begin
          shift_d = {shift_q[ADC_BITS-2:0], miso};
        end
      end
    end
    sclk_d = !cs_d && seg_d[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      done_q   <= 1'b0;
      div_q    <= '0;
      seg_q    <= '0;
      shift_q  <= '0;
      sample_q <= '0;
    end else begin
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      done_q   <= done_d;
      div_q    <= div_d;
      seg_q    <= seg_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
    end
  end

  assign cs     = cs_q;
  assign sclk   = sclk_q;
  assign done   = done_q;
  assign sample = sample_q;

endmodule

// File: rtl/mss_capture_core.sv
// Frame-capture sequencer: scans every sensor row/column with pointer/value
// pulses, converts each pixel through the SPI ADC and shows status on LEDs.
module mss_capture_core
  import mss_capture_pkg::*;
#(
  parameter int ROWS     = DEF_ROWS,
  parameter int COLS     = DEF_COLS,
  parameter int SETTLE   = DEF_SETTLE,
  parameter int SPI_DIV  = DEF_SPI_DIV,
  parameter int SPI_BITS = DEF_SPI_BITS,
  parameter int ADC_BITS = DEF_ADC_BITS,
  parameter int LED_W    = DEF_LED_W
) (
  input  logic             SYSCLK,
  input  logic             MSS_RESET_N,
  input  logic             miso,
  output logic             cs,
  output logic             SPI_CLK,
  output logic             startCaptureTP,
  output logic             resp,
  output logic             incp,
  output logic             resv,
  output logic             incv,
  output logic             inphi,
  output logic [LED_W-1:0] ledsout
);

  localparam int FC_W = LED_W / 2;
  localparam logic [7:0]       ROW_LAST    = 8'(ROWS - 1);
  localparam logic [7:0]       COL_LAST    = 8'(COLS - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CNT_W-1:0] NEXT_LAST   = CNT_W'(SPI_DIV - 1);

  state_e              state_q, state_d;
  logic [7:0]          row_q, row_d;
  logic [7:0]          col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gap_q, gap_d;
  logic [FC_W-1:0]     frame_q, frame_d;
  logic [4:0]          pulse_q, pulse_d;
  logic                start_tp_q, start_tp_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic [CNT_W-1:0]    sel_cnt, seq_last;
  logic                adc_start, adc_done;
  logic [ADC_BITS-1:0] adc_sample;
  logic                sample_unused;

  spi_adc_rx #(
    .SPI_DIV  (SPI_DIV),
    .SPI_BITS (SPI_BITS),
    .ADC_BITS (ADC_BITS)
  ) u_adc (
    .clk    (SYSCLK),
    .rst_n  (MSS_RESET_N),
    .start  (adc_start),
    .miso   (miso),
    .cs     (cs),
    .sclk   (SPI_CLK),
    .done   (adc_done),
    .sample (adc_sample)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    pulse_d    = '0;
    start_tp_d = 1'b0;
    adc_start  = 1'b0;
    sel_cnt    = CNT_W'(COLSEL);
    seq_last   = '0;
    case (state_q)
      ST_IDLE: state_d = ST_FRAME;
      ST_FRAME: begin
        start_tp_d = 1'b1;
        row_d      = '0;
        cnt_d      = '0;
        gap_d      = 1'b0;
        state_d    = ST_SET_ROW;
      end
      // Pointer select: resp, sel x incp, resv, then value x incv; every
      // pulse step is followed by one gap cycle.
      ST_SET_ROW, ST_SET_COL: begin
        if (state_q == ST_SET_ROW) begin
          sel_cnt  = CNT_W'(ROWSEL);
          seq_last = CNT_W'(ROWSEL + 1) + CNT_W'(row_q);
        end else begin
          sel_cnt  = CNT_W'(COLSEL);
          seq_last = CNT_W'(COLSEL + 1) + CNT_W'(col_q);
        end
        if (!gap_q) begin
          gap_d = 1'b1;
          if (cnt_q == '0)                         pulse_d[P_RESP] = 1'b1;
          else if (cnt_q <= sel_cnt)               pulse_d[P_INCP] = 1'b1;
          else if (cnt_q == sel_cnt + CNT_W'(1))   pulse_d[P_RESV] = 1'b1;
          else                                     pulse_d[P_INCV] = 1'b1;
        end else begin
          gap_d = 1'b0;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == seq_last) begin
            cnt_d = '0;
            if (state_q == ST_SET_ROW) begin
              col_d   = '0;
              state_d = ST_SET_COL;
            end else begin
              state_d = ST_SETTLE;
            end
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_PHI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Conversion starts only after inphi has dropped again.
      ST_PHI: begin
        if (!gap_q) begin
          pulse_d[P_INPHI] = 1'b1;
          gap_d            = 1'b1;
        end else begin
          gap_d     = 1'b0;
          adc_start = 1'b1;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (adc_done) begin
          cnt_d   = '0;
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (cnt_q < NEXT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (col_q < COL_LAST) begin
            col_d   = col_q + 8'd1;
            state_d = ST_SET_COL;
          end else if (row_q < ROW_LAST) begin
            row_d   = row_q + 8'd1;
            state_d = ST_SET_ROW;
          end else begin
            frame_d = frame_q + FC_W'(1);
            state_d = ST_FRAME;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    leds_d = {frame_q, adc_sample[ADC_BITS-1 -: FC_W]};
  end

  always_ff @(posedge SYSCLK or negedge MSS_RESET_N) begin
    if (!MSS_RESET_N) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      gap_q      <= 1'b0;
      frame_q    <= '0;
      pulse_q    <= '0;
      start_tp_q <= 1'b0;
      leds_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      frame_q    <= frame_d;
      pulse_q    <= pulse_d;
      start_tp_q <= start_tp_d;
      leds_q     <= leds_d;
    end
  end

  // Only the top bits of the sample reach the LEDs.
  assign sample_unused = ^{1'b0, adc_sample};

  assign resp           = pulse_q[P_RESP];
  assign incp           = pulse_q[P_INCP];
  assign resv           = pulse_q[P_RESV];
  assign incv           = pulse_q[P_INCV];
  assign inphi          = pulse_q[P_INPHI];
  assign startCaptureTP = start_tp_q;
  assign ledsout        = leds_q;

endmodule

// File: tb/tb_mss_capture_core.sv
// Directed bench for mss_capture_core with a small 2x3 frame and SPI_DIV=3;
// a negedge monitor models the ADC and tallies pulses and SPI timing.
module tb_mss_capture_core;

  localparam int ROWS = 2, COLS = 3, SETTLE = 4, SPI_DIV = 3;
  localparam int SPI_BITS = 16, ADC_BITS = 10, LED_W = 8;

  logic SYSCLK = 1'b0;
  logic MSS_RESET_N = 1'b0;
  logic miso = 1'b0;
  logic cs, SPI_CLK, startCaptureTP, resp, incp, resv, incv, inphi;
  logic [LED_W-1:0] ledsout;

  mss_capture_core #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .SPI_DIV(SPI_DIV),
    .SPI_BITS(SPI_BITS), .ADC_BITS(ADC_BITS), .LED_W(LED_W)
  ) dut (
    .SYSCLK(SYSCLK), .MSS_RESET_N(MSS_RESET_N), .miso(miso), .cs(cs),
    .SPI_CLK(SPI_CLK), .startCaptureTP(startCaptureTP), .resp(resp),
    .incp(incp), .resv(resv), .incv(incv), .inphi(inphi), .ledsout(ledsout)
  );

  always #5 SYSCLK = ~SYSCLK;

  int vectors = 0, miscompares = 0;
  logic [15:0] pat = 16'h0000;

  int frames_seen = 0, wins = 0, bad_pulse = 0, bad_run = 0, bad_win = 0;
  int n_resp = 0, n_incp = 0, n_resv = 0, n_incv = 0, n_inphi = 0, n_wins = 0;
  int fr_resp = 0, fr_incp = 0, fr_resv = 0, fr_incv = 0, fr_inphi = 0, fr_wins = 0;
  logic [7:0]  fr_leds = 8'h00;
  logic [17:0] seq = '0;
  int seq_n = 0;
  logic cs_prev = 1'b1, run_lvl = 1'b0;
  int run_len = 0, rises = 0;
  logic [4:0] prev_p = '0, p;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[%0t] FAIL %s: got %0h, expected %0h", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s: %0h", $time, tag, got);
    end
  endtask

  // ADC model and activity monitor, sampled mid-cycle.
  initial forever begin
    @(negedge SYSCLK);
    if (!MSS_RESET_N) begin
      n_resp = 0; n_incp = 0; n_resv = 0; n_incv = 0; n_inphi = 0; n_wins = 0;
      seq = '0; seq_n = 0; cs_prev = 1'b1; prev_p = '0; rises = 0; run_len = 0;
      miso = 1'b0;
    end else begin
      p = {inphi, incv, resv, incp, resp};
      if ($countones(p) > 1) bad_pulse++;
      if ((p & prev_p) != 5'd0) bad_pulse++;
      prev_p = p;
      n_resp += int'(resp); n_incp += int'(incp); n_resv += int'(resv);
      n_incv += int'(incv); n_inphi += int'(inphi);
      for (int i = 0; i < 5; i++) begin
        if (p[i] && seq_n < 6) begin
          seq = {seq[14:0], 3'(i)};
          seq_n++;
        end
      end
      if (cs && SPI_CLK) bad_run++;
      if (!cs) begin
        if (cs_prev) begin
          rises = 0; run_len = 1; run_lvl = SPI_CLK;
          if (SPI_CLK) bad_run++;
        end else if (SPI_CLK == run_lvl) begin
          run_len++;
        end else begin
          if (run_len != SPI_DIV) bad_run++;
          if (SPI_CLK) rises++;
          run_lvl = SPI_CLK; run_len = 1;
        end
      end else if (!cs_prev) begin
        if (run_len != SPI_DIV || run_lvl) bad_run++;
        if (rises != SPI_BITS) bad_win++;
        wins++; n_wins++;
      end
      cs_prev = cs;
      if (startCaptureTP) begin
        fr_resp = n_resp; fr_incp = n_incp; fr_resv = n_resv; fr_incv = n_incv;
        fr_inphi = n_inphi; fr_wins = n_wins; fr_leds = ledsout;
        n_resp = 0; n_incp = 0; n_resv = 0; n_incv = 0; n_inphi = 0; n_wins = 0;
        frames_seen++;
      end
      miso = (!cs && rises < SPI_BITS) ? pat[15 - rises] : 1'b0;
    end
  end

  task automatic wait_frame(input int target);
    int n = 0;
    while (frames_seen < target && n < 4000) begin
      @(posedge SYSCLK);
      n++;
    end
    check_vec("frame_wait", 32'(frames_seen >= target), 1);
  endtask

  task automatic wait_win(input int target);
    int n = 0;
    while (wins < target && n < 4000) begin
      @(posedge SYSCLK);
      n++;
    end
    check_vec("conv_wait", 32'(wins >= target), 1);
  endtask

  task automatic reset_outputs(input string tag);
    check_vec({tag, "_cs"}, 32'(cs), 1);
    check_vec({tag, "_sclk"}, 32'(SPI_CLK), 0);
    check_vec({tag, "_leds"}, 32'(ledsout), 0);
    check_vec({tag, "_pulses"}, 32'({startCaptureTP, inphi, incv, resv, incp, resp}), 0);
  endtask

  task automatic release_and_check_start();
    @(negedge SYSCLK);
    #1 MSS_RESET_N = 1'b1;
    @(posedge SYSCLK); #1 check_vec("tp_edge1", 32'(startCaptureTP), 0);
    @(posedge SYSCLK); #1 check_vec("tp_edge2", 32'(startCaptureTP), 1);
    @(posedge SYSCLK); #1 check_vec("tp_edge3", 32'(startCaptureTP), 0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] exp_leds);
    check_vec({tag, "_resp"}, 32'(fr_resp), 8);
    check_vec({tag, "_incp"}, 32'(fr_incp), 2);
    check_vec({tag, "_resv"}, 32'(fr_resv), 8);
    check_vec({tag, "_incv"}, 32'(fr_incv), 7);
    check_vec({tag, "_inphi"}, 32'(fr_inphi), 6);
    check_vec({tag, "_cs_windows"}, 32'(fr_wins), 6);
    check_vec({tag, "_leds"}, 32'(fr_leds), 32'(exp_leds));
  endtask

  task automatic sample_check(input string tag, input logic [15:0] bits, input logic [3:0] exp_nib);
    pat = bits;
    wait_win(wins + 1);
    repeat (2) @(negedge SYSCLK);
    check_vec(tag, 32'(ledsout[3:0]), 32'(exp_nib));
  endtask

  initial begin
    int base, n;
    logic [17:0] exp_seq;
    exp_seq = {3'd0, 3'd1, 3'd2, 3'd0, 3'd2, 3'd4};

    repeat (10) @(negedge SYSCLK);
    reset_outputs("rst");
    release_and_check_start();

    wait_frame(2);
    check_frame("frame1", 8'h10);
    wait_frame(3);
    check_vec("frame2_leds", 32'(fr_leds), 32'h20);

    sample_check("miso_ones", 16'hFFFF, 4'hF);
    sample_check("miso_1010", 16'b1010000000_000000, 4'hA);
    sample_check("tail_ignored", 16'b0000000000_111111, 4'h0);
    sample_check("miso_5fff", 16'h5FFF, 4'h5);
    sample_check("miso_ones2", 16'hFFFF, 4'hF);

    n = 0;
    do begin
      @(negedge SYSCLK);
      n++;
    end while (!(!cs && SPI_CLK) && n < 4000);
    check_vec("conv_found", 32'(n < 4000), 1);
    #1 MSS_RESET_N = 1'b0;
    #1 reset_outputs("midconv");

    repeat (3) @(negedge SYSCLK);
    base = frames_seen;
    release_and_check_start();
    wait_frame(base + 2);
    check_frame("after_rst", 8'h1F);
    check_vec("after_rst_seq", 32'(seq), 32'(exp_seq));

    check_vec("pulse_rule", 32'(bad_pulse), 0);
    check_vec("spi_runs", 32'(bad_run), 0);
    check_vec("spi_rises", 32'(bad_win), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
